// File: rtl/ibex_pkg.sv
// Shared Ibex constants: base opcodes and compressed quadrant-1 encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   opcode_e        32-bit major opcodes used by the fetch-side predictor
//   C1_FUNCT3_*     funct3 values of the compressed quadrant-1 jumps/branches
//   br_class_t      one-hot-ish control-transfer class flags
package ibex_pkg;

  typedef enum logic [6:0] {
    OPCODE_OP_IMM = 7'h13,
    OPCODE_BRANCH = 7'h63,
    OPCODE_JALR   = 7'h67,
    OPCODE_JAL    = 7'h6f
  } opcode_e;

  // Compressed quadrant 1 (instr[1:0] == 2'b01)
  localparam logic [1:0] C_OPCODE_Q1    = 2'b01;
  localparam logic [2:0] C1_FUNCT3_JAL  = 3'b001;
  localparam logic [2:0] C1_FUNCT3_J    = 3'b101;
  localparam logic [2:0] C1_FUNCT3_BEQZ = 3'b110;
  localparam logic [2:0] C1_FUNCT3_BNEZ = 3'b111;

  typedef struct packed {
    logic j;   // JAL
    logic b;   // conditional branch (B-type)
    logic cj;  // C.J / C.JAL
    logic cb;  // C.BEQZ / C.BNEZ
  } br_class_t;

endpackage

// File: rtl/ibex_branch_imm_dec.sv
// Classifies an instruction as JAL / B / C.J(AL) / C.B(EQ|NE)Z and selects its offset.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   instr_i  [31:0]  instruction word (compressed forms use [15:0])
//   cls_o            control-transfer class flags
//   imm_o    [31:0]  sign-extended offset, priority j > b > cj > cb, default B
module ibex_branch_imm_dec
  import ibex_pkg::*;
(
  input  logic [31:0] instr_i,
  output br_class_t   cls_o,
  output logic [31:0] imm_o
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;
  logic        is_q1;

  assign is_q1 = (instr_i[1:0] == C_OPCODE_Q1);

  assign cls_o.j  = (instr_i[6:0] == OPCODE_JAL);
  assign cls_o.b  = (instr_i[6:0] == OPCODE_BRANCH);
  assign cls_o.cj = is_q1 & ((instr_i[15:13] == C1_FUNCT3_J) |
                             (instr_i[15:13] == C1_FUNCT3_JAL));
  assign cls_o.cb = is_q1 & ((instr_i[15:13] == C1_FUNCT3_BEQZ) |
                             (instr_i[15:13] == C1_FUNCT3_BNEZ));

  assign imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_b  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_cj = {{21{instr_i[12]}}, instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                   instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
  assign imm_cb = {{24{instr_i[12]}}, instr_i[6:5], instr_i[2], instr_i[11:10],
                   instr_i[4:3], 1'b0};

  always_comb begin
    imm_o = imm_b;
    if (cls_o.j) begin
      imm_o = imm_j;
    end else if (cls_o.b) begin
      imm_o = imm_b;
    end else if (cls_o.cj) begin
      imm_o = imm_cj;
    end else if (cls_o.cb) begin
      imm_o = imm_cb;
    end
  end

endmodule

// File: rtl/ibex_branch_predict_bht.sv
// Same-cycle taken/target predictor: per-PC saturating counters with static BTFN fallback.
// Latency: prediction is combinational; updates/flush take effect after the next clock edge.
// Backpressure: none; every update_valid_i pulse is absorbed unless reset or flush wins.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   fetch_rdata_i/pc_i/valid_i   instruction being fetched
//   predict_branch_taken_o/pc_o  predicted direction and target
//   update_valid_i/pc_i/taken_i  resolved conditional branch from execute
//   flush_i                      invalidate the whole table
module ibex_branch_predict_bht
  import ibex_pkg::*;
#(
  parameter int unsigned NumEntries = 64,
  parameter int unsigned CtrWidth   = 2,
  parameter bit          BhtEnable  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        flush_i
);

  localparam int unsigned IdxW = $clog2(NumEntries);

  br_class_t   cls;
  logic [31:0] imm;
  logic        entry_vld;
  logic        entry_msb;
  logic        cond_taken;

  ibex_branch_imm_dec u_imm_dec (
    .instr_i (fetch_rdata_i),
    .cls_o   (cls),
    .imm_o   (imm)
  );

  assign predict_branch_pc_o = fetch_pc_i + imm;

  // A valid entry overrides the static guess; otherwise backward (negative offset) is taken.
  assign cond_taken = entry_vld ? entry_msb : imm[31];

  assign predict_branch_taken_o = fetch_valid_i &
                                  (cls.j | cls.cj | ((cls.b | cls.cb) & cond_taken));

  if (BhtEnable) begin : g_bht
    localparam logic [CtrWidth-1:0] CtrWeakT  = CtrWidth'(1) << (CtrWidth - 1);
    localparam logic [CtrWidth-1:0] CtrWeakNt = CtrWeakT - CtrWidth'(1);
    localparam logic [CtrWidth-1:0] CtrMax    = {CtrWidth{1'b1}};

    logic [NumEntries-1:0] valid_q;
    logic [CtrWidth-1:0]   ctr_q [NumEntries];
    logic [IdxW-1:0]       rd_idx;
    logic [IdxW-1:0]       wr_idx;
    logic [CtrWidth-1:0]   ctr_old;
    logic [CtrWidth-1:0]   ctr_d;
    logic                  unused_upd_pc;

    // Halfword-granular index, no tag: aliasing between PCs is accepted.
    assign rd_idx  = fetch_pc_i[IdxW:1];
    assign wr_idx  = update_pc_i[IdxW:1];
    assign ctr_old = ctr_q[wr_idx];

    always_comb begin
      ctr_d = ctr_old;
      if (!valid_q[wr_idx]) begin
        // First sighting starts just on the observed side of the threshold.
        ctr_d = update_taken_i ? CtrWeakT : CtrWeakNt;
      end else if (update_taken_i) begin
        ctr_d = (ctr_old == CtrMax) ? ctr_old : ctr_old + CtrWidth'(1);
      end else begin
        ctr_d = (ctr_old == '0) ? ctr_old : ctr_old - CtrWidth'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < NumEntries; i++) begin
          valid_q[i] <= 1'b0;
          ctr_q[i]   <= CtrWeakNt;
        end
      end else if (flush_i) begin
        // Counters are left stale; an invalid entry is re-seeded on its next update.
        valid_q <= '0;
      end else if (update_valid_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= ctr_d;
      end
    end

    assign entry_vld = valid_q[rd_idx];
    assign entry_msb = ctr_q[rd_idx][CtrWidth-1];

    assign unused_upd_pc = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};
  end else begin : g_static
    logic unused_inputs;

    assign entry_vld     = 1'b0;
    assign entry_msb     = 1'b0;
    assign unused_inputs = ^{clk_i, rst_i, update_valid_i, update_pc_i, update_taken_i, flush_i};
  end

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
module tb_ibex_branch_predict_bht;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fv, uv, ut, flush;
  logic [31:0] rdata, pc, upc;
  logic [2:0]  tk;
  logic [31:0] pt0, pt1, pt2;

  // Current fetch as the bench intends it: class (0 other, 1 J, 2 B, 3 CJ, 4 CB, 5 compressed other)
  int          cls;
  logic [31:0] imm;

  int n_cmp = 0;
  int n_err = 0;

  // Reference table per configuration: valid flag and counter value as plain integers.
  bit mv [3][64];
  int mc [3][64];

  // Config 0: 64 entries, 2-bit. Config 1: 4 entries, 3-bit. Config 2: static only.
  ibex_branch_predict_bht #(.NumEntries(64), .CtrWidth(2), .BhtEnable(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(rdata), .fetch_pc_i(pc), .fetch_valid_i(fv),
    .predict_branch_taken_o(tk[0]), .predict_branch_pc_o(pt0),
    .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut), .flush_i(flush));

  ibex_branch_predict_bht #(.NumEntries(4), .CtrWidth(3), .BhtEnable(1'b1)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(rdata), .fetch_pc_i(pc), .fetch_valid_i(fv),
    .predict_branch_taken_o(tk[1]), .predict_branch_pc_o(pt1),
    .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut), .flush_i(flush));

  ibex_branch_predict_bht #(.NumEntries(64), .CtrWidth(2), .BhtEnable(1'b0)) u_dut_st (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(rdata), .fetch_pc_i(pc), .fetch_valid_i(fv),
    .predict_branch_taken_o(tk[2]), .predict_branch_pc_o(pt2),
    .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut), .flush_i(flush));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ent(input int c);
    return (c == 1) ? 4 : 64;
  endfunction

  function automatic int wid(input int c);
    return (c == 1) ? 3 : 2;
  endfunction

  function automatic bit en(input int c);
    return c != 2;
  endfunction

  // Random even offset representable in 'bits' signed bits.
  function automatic logic [31:0] rand_imm(input int bits);
    logic [31:0] r;
    r    = $urandom;
    r[0] = 1'b0;
    r    = r << (32 - bits);
    return $unsigned($signed(r) >>> (32 - bits));
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) return r;
    return (r & ~32'h1F) | (32'($urandom_range(0, 15)) << 1);
  endfunction

  // Encode an instruction of the requested class carrying offset im.
  task automatic set_fetch(input int c, input logic [31:0] im, input logic [31:0] p, input bit v);
    logic [31:0] r;
    r   = $urandom;
    cls = c;
    imm = im;
    pc  = p;
    fv  = v;
    case (c)
      1: rdata = {im[20], im[10:1], im[11], im[19:12], r[4:0], 7'h6f};
      2: rdata = {im[12], im[10:5], r[4:0], r[9:5], r[12:10], im[4:1], im[11], 7'h63};
      3: rdata = {r[31:16], (r[13] ? 3'b101 : 3'b001), im[11], im[4], im[9:8], im[10],
                  im[6], im[7], im[3:1], im[5], 2'b01};
      4: rdata = {r[31:16], (r[13] ? 3'b110 : 3'b111), im[8], im[4:3], r[2:0], im[7:6],
                  im[2:1], im[5], 2'b01};
      5: rdata = {r[31:2], (r[14] ? 2'b00 : 2'b10)};
      default: rdata = {r[31:7], 7'h13};
    endcase
  endtask

  function automatic bit m_taken(input int c);
    int idx;
    if (!fv) return 1'b0;
    if (cls == 1 || cls == 3) return 1'b1;
    if (cls == 2 || cls == 4) begin
      idx = int'((pc >> 1) % ent(c));
      if (en(c) && mv[c][idx]) return mc[c][idx] >= (1 << (wid(c) - 1));
      return $signed(imm) < 0;
    end
    return 1'b0;
  endfunction

  task automatic m_step();
    int idx, half, top;
    for (int c = 0; c < 3; c++) begin
      if (rst || flush) begin
        for (int i = 0; i < 64; i++) mv[c][i] = 1'b0;
      end else if (uv && en(c)) begin
        idx  = int'((upc >> 1) % ent(c));
        half = 1 << (wid(c) - 1);
        top  = (1 << wid(c)) - 1;
        if (!mv[c][idx]) begin
          mv[c][idx] = 1'b1;
          mc[c][idx] = ut ? half : half - 1;
        end else if (ut) begin
          mc[c][idx] = (mc[c][idx] < top) ? mc[c][idx] + 1 : top;
        end else begin
          mc[c][idx] = (mc[c][idx] > 0) ? mc[c][idx] - 1 : 0;
        end
      end
    end
  endtask

  // Inputs are driven on the falling edge; outputs are checked 1ns later.
  task automatic settle();
    logic [31:0] pts [3];
    #1;
    pts[0] = pt0;
    pts[1] = pt1;
    pts[2] = pt2;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("taken[cfg%0d]", c), 32'(tk[c]), 32'(m_taken(c)));
      if (cls >= 1 && cls <= 4)
        chk($sformatf("target[cfg%0d]", c), pts[c], pc + imm);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; uv = 1'b0; ut = 1'b0; flush = 1'b0; upc = '0;
    set_fetch(0, '0, '0, 1'b0);
    @(negedge clk);
    settle();
    chk("reset_taken", 32'(tk), 32'h0);
    advance();
    rst = 1'b0;

    // Static BTFN straight after reset
    set_fetch(2, 32'hFFFF_FFF8, 32'h100, 1'b1); settle();
    chk("beq_back_taken", 32'(tk[0]), 32'h1);
    chk("beq_back_pc", pt0, 32'h0F8);
    advance();
    set_fetch(2, 32'h10, 32'h100, 1'b1); settle();
    chk("beq_fwd_taken", 32'(tk[0]), 32'h0);
    chk("beq_fwd_pc", pt0, 32'h110);
    advance();

    // Train not-taken, then saturate at the floor
    set_fetch(0, '0, '0, 1'b0);
    uv = 1'b1; upc = 32'h100; ut = 1'b0;
    repeat (3) begin settle(); advance(); end
    uv = 1'b0;
    set_fetch(2, 32'hFFFF_FFF8, 32'h100, 1'b1); settle();
    chk("trained_nt", 32'(tk[0]), 32'h0);
    advance();
    set_fetch(0, '0, '0, 1'b0);
    uv = 1'b1; ut = 1'b0; settle(); advance();
    ut = 1'b1; settle(); advance();
    uv = 1'b0;
    set_fetch(2, 32'hFFFF_FFF8, 32'h100, 1'b1); settle();
    chk("floor_no_wrap", 32'(tk[0]), 32'h0);
    advance();

    // C.J is always taken when valid; target independent of valid
    set_fetch(3, 32'h20, 32'h200, 1'b1); settle();
    chk("cj_taken", 32'(tk[0]), 32'h1);
    chk("cj_pc", pt0, 32'h220);
    advance();
    set_fetch(3, 32'h20, 32'h200, 1'b0); settle();
    chk("cj_novalid_taken", 32'(tk[0]), 32'h0);
    chk("cj_novalid_pc", pt0, 32'h220);
    advance();

    // Same-cycle update and lookup: no bypass
    uv = 1'b1; upc = 32'h104; ut = 1'b1;
    set_fetch(2, 32'h10, 32'h104, 1'b1); settle();
    chk("same_cycle_old", 32'(tk[0]), 32'h0);
    advance();
    uv = 1'b0; settle();
    chk("next_cycle_new", 32'(tk[0]), 32'h1);
    advance();

    // Strongly taken, then flush with a concurrent update that must be dropped
    set_fetch(0, '0, '0, 1'b0);
    uv = 1'b1; upc = 32'h100; ut = 1'b1;
    repeat (4) begin settle(); advance(); end
    uv = 1'b0;
    set_fetch(2, 32'h10, 32'h100, 1'b1); settle();
    chk("trained_t", 32'(tk[0]), 32'h1);
    advance();
    flush = 1'b1; uv = 1'b1; settle(); advance();
    flush = 1'b0; uv = 1'b0; settle();
    chk("flush_btfn", 32'(tk[0]), 32'h0);
    advance();

    // Aliasing in the 4-entry table; static instance ignores updates
    set_fetch(0, '0, '0, 1'b0);
    uv = 1'b1; upc = 32'h100; ut = 1'b1; settle(); advance();
    uv = 1'b0;
    set_fetch(2, 32'h10, 32'h108, 1'b1); settle();
    chk("alias_4entry", 32'(tk[1]), 32'h1);
    chk("alias_64entry", 32'(tk[0]), 32'h0);
    chk("static_ignores", 32'(tk[2]), 32'h0);
    advance();

    // Randomized traffic against the reference model
    repeat (3000) begin
      int          c;
      logic [31:0] im;
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      uv    = $urandom_range(0, 1) == 1;
      ut    = $urandom_range(0, 1) == 1;
      upc   = pick_pc();
      c     = int'($urandom_range(0, 5));
      case (c)
        1:       im = rand_imm(21);
        2:       im = rand_imm(13);
        3:       im = rand_imm(12);
        4:       im = rand_imm(9);
        default: im = '0;
      endcase
      set_fetch(c, im, pick_pc(), $urandom_range(0, 4) != 0);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
